// File: rtl/axis_ready_sink.sv
// axis_ready_sink: AXI4-Stream byte sink with a run-time programmable tready policy,
// an accepted-beat counter and an optional incrementing-byte pattern checker.
// Optional feature macro: AXIS_READY_SINK_CHECK_EN (pattern checker and err_cnt logic).
module axis_ready_sink #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [2:0]        policy,
   input  logic [7:0]        low_time,
   input  logic [7:0]        high_time,
   input  logic [7:0]        events,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [DATA_W-1:0] last_data
);

   localparam int unsigned POL_W = 3;
   localparam int unsigned TIM_W = 8;

   typedef enum logic [1:0] {
      ST_PRE,
      ST_IDLE,
      ST_LOW,
      ST_HIGH
   } state_t;

   typedef enum logic [1:0] {
      MODE_ALWAYS,
      MODE_OSC,
      MODE_SINGLE,
      MODE_EVENTS
   } mode_t;

   state_t             state;
   state_t             state_nxt;
   state_t             start_state;
   mode_t              cur_mode;
   logic [POL_W-1:0]   pol;
   logic [POL_W-1:0]   pol_nxt;
   logic [POL_W-1:0]   pol_sample;
   logic [TIM_W-1:0]   phase_cnt;
   logic [TIM_W-1:0]   hs_cnt;
   logic [TIM_W-1:0]   low_last;
   logic [TIM_W-1:0]   high_last;
   logic [TIM_W-1:0]   events_last;
   logic               restart;
   logic               high_done;
   logic               hs;

   assign hs = s_axis_tvalid & s_axis_tready;

   // Terminal counts: a zero setting behaves as one.
   assign low_last    = (low_time  == '0) ? '0 : low_time  - TIM_W'(1);
   assign high_last   = (high_time == '0) ? '0 : high_time - TIM_W'(1);
   assign events_last = (events    == '0) ? '0 : events    - TIM_W'(1);

   // Live policy decode used at phase-start points (7 aliases ALWAYS).
   always_comb begin
      pol_sample  = policy;
      start_state = ST_IDLE;
      case (policy)
         3'd0, 3'd7: begin
            pol_sample  = 3'd0;
            start_state = ST_HIGH;
         end
         3'd1, 3'd2, 3'd3: start_state = ST_LOW;
         default:          start_state = ST_IDLE;
      endcase
   end

   // Latched policy decode: AV_* variants share the HIGH exit rule of their base mode.
   always_comb begin
      cur_mode = MODE_ALWAYS;
      case (pol)
         3'd1, 3'd4: cur_mode = MODE_OSC;
         3'd2, 3'd5: cur_mode = MODE_SINGLE;
         3'd3, 3'd6: cur_mode = MODE_EVENTS;
         default:    cur_mode = MODE_ALWAYS;
      endcase
   end

   // Next-state logic; restart flags a state entry so the phase counters clear.
   always_comb begin
      state_nxt = state;
      pol_nxt   = pol;
      restart   = 1'b0;
      high_done = 1'b0;
      case (state)
         ST_PRE: begin
            restart   = 1'b1;
            state_nxt = start_state;
            pol_nxt   = pol_sample;
         end
         ST_IDLE: begin
            if (s_axis_tvalid) begin
               restart   = 1'b1;
               state_nxt = ST_LOW;
            end
         end
         ST_LOW: begin
            if (phase_cnt == low_last) begin
               restart   = 1'b1;
               state_nxt = ST_HIGH;
            end
         end
         ST_HIGH: begin
            case (cur_mode)
               MODE_OSC:    high_done = (phase_cnt == high_last);
               MODE_SINGLE: high_done = hs;
               MODE_EVENTS: high_done = hs && (hs_cnt == events_last);
               default:     high_done = 1'b1;
            endcase
            if (high_done) begin
               restart   = 1'b1;
               state_nxt = start_state;
               pol_nxt   = pol_sample;
            end
         end
         default: begin
            restart   = 1'b1;
            state_nxt = ST_PRE;
         end
      endcase
   end

   // State and latched-policy registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= ST_PRE;
         pol   <= '0;
      end else begin
         state <= state_nxt;
         pol   <= pol_nxt;
      end
   end

   // Phase cycle counter and handshake counter, both cleared on every state entry.
   always_ff @(posedge aclk) begin
      if (areset || restart) begin
         phase_cnt <= '0;
         hs_cnt    <= '0;
      end else begin
         phase_cnt <= phase_cnt + TIM_W'(1);
         if (hs) begin
            hs_cnt <= hs_cnt + TIM_W'(1);
         end
      end
   end

   // tready registered from the next state, so it drops on the exit handshake edge.
   always_ff @(posedge aclk) begin
      if (areset) begin
         s_axis_tready <= 1'b0;
      end else begin
         s_axis_tready <= (state_nxt == ST_HIGH);
      end
   end

   // Accepted-beat counter (wrapping) and last accepted data.
   always_ff @(posedge aclk) begin
      if (areset) begin
         beat_cnt  <= '0;
         last_data <= '0;
      end else if (hs) begin
         beat_cnt  <= beat_cnt + CNT_W'(1);
         last_data <= s_axis_tdata;
      end
   end

`ifdef AXIS_READY_SINK_CHECK_EN
   logic [DATA_W-1:0] expected;

   // Incrementing-byte checker; reloads from the received byte so it resynchronises.
   always_ff @(posedge aclk) begin
      if (areset) begin
         expected <= '0;
         err_cnt  <= '0;
      end else if (hs) begin
         if ((s_axis_tdata != expected) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
         expected <= s_axis_tdata + DATA_W'(1);
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_ready_sink.sv
// Scoreboard bench for axis_ready_sink: a phase-level reference model predicts
// tready and the counters each cycle; a monitor compares them on the falling edge.
module tb_axis_ready_sink;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 16;
`ifdef AXIS_READY_SINK_CHECK_EN
   localparam int EXP_ERR = 1;
`else
   localparam int EXP_ERR = 0;
`endif

   logic              clk = 1'b0;
   logic              areset = 1'b1;
   logic [DATA_W-1:0] tdata = '0;
   logic              tvalid = 1'b0;
   logic              tready;
   logic [2:0]        policy = 3'd0;
   logic [7:0]        low_time = 8'd1;
   logic [7:0]        high_time = 8'd1;
   logic [7:0]        events = 8'd1;
   logic [CNT_W-1:0]  beat_cnt;
   logic [CNT_W-1:0]  err_cnt;
   logic [DATA_W-1:0] last_data;

   always #5 clk = ~clk;

   axis_ready_sink #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .aclk          (clk),
      .areset        (areset),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .policy        (policy),
      .low_time      (low_time),
      .high_time     (high_time),
      .events        (events),
      .beat_cnt      (beat_cnt),
      .err_cnt       (err_cnt),
      .last_data     (last_data)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   typedef struct packed {
      logic        rdy;
      logic [15:0] beats;
      logic [15:0] errs;
      logic [7:0]  last;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: phase kind plus a down-counter of cycles or handshakes left.
   int m_phase;   // 0 pre, 1 wait-for-valid, 2 low, 3 high
   int m_pol;
   int m_rem;
   bit m_rdy;
   int m_beats, m_errs, m_last, m_expect;
   bit hs_last;

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic void m_start();
      int p;
      p = (int'(policy) == 7) ? 0 : int'(policy);
      m_pol = p;
      if (p == 0) m_phase = 3;
      else if (p <= 3) begin
         m_phase = 2;
         m_rem   = eff(int'(low_time));
      end else m_phase = 1;
   endfunction

   always @(posedge clk) begin
      bit hs;
      int base;
      exp_t e;
      hs_last = tvalid & tready;
      if (areset) begin
         m_phase = 0; m_rdy = 0; m_beats = 0; m_errs = 0; m_last = 0; m_expect = 0;
      end else begin
         hs   = tvalid && m_rdy;
         base = (m_pol - 1) % 3;  // 0 osc, 1 single, 2 events
         if (hs) begin
            m_beats = (m_beats + 1) % 65536;
            m_last  = int'(tdata);
`ifdef AXIS_READY_SINK_CHECK_EN
            if (int'(tdata) != m_expect && m_errs < 65535) m_errs++;
`endif
            m_expect = (int'(tdata) + 1) % 256;
         end
         case (m_phase)
            0: m_start();
            1: if (tvalid) begin m_phase = 2; m_rem = eff(int'(low_time)); end
            2: begin
               m_rem--;
               if (m_rem == 0) begin
                  m_phase = 3;
                  m_rem = (base == 0) ? eff(int'(high_time)) : (base == 1) ? 1 : eff(int'(events));
               end
            end
            default: begin
               if (m_pol == 0) m_start();
               else begin
                  if (base == 0 || hs) m_rem--;
                  if (m_rem == 0) m_start();
               end
            end
         endcase
         m_rdy = (m_phase == 3);
      end
      e.rdy   = m_rdy;
      e.beats = 16'(m_beats);
      e.errs  = 16'(m_errs);
      e.last  = 8'(m_last);
      exp_q.push_back(e);
   end

   // Monitor: pops one prediction per cycle and compares the registered outputs.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("tready", 32'(tready), 32'(e.rdy));
         check("beat_cnt", 32'(beat_cnt), 32'(e.beats));
         check("err_cnt", 32'(err_cnt), 32'(e.errs));
         check("last_data", 32'(last_data), 32'(e.last));
      end
   end

   logic [7:0] tx_q[$];

   task automatic do_reset(input logic [2:0] p, input logic [7:0] lt, input logic [7:0] ht,
                           input logic [7:0] ev);
      @(negedge clk);
      areset = 1'b1; tvalid = 1'b0;
      policy = p; low_time = lt; high_time = ht; events = ev;
      @(negedge clk);
      areset = 1'b0;
   endtask

   // Master: presents tx_q bytes, advancing on each observed handshake.
   task automatic run_stream(input int vmode, input int budget, output int cycles);
      int sent;
      sent = 0; cycles = 0;
      while (sent < tx_q.size() && cycles < budget) begin
         case (vmode)
            0:       tvalid = 1'b1;
            1:       tvalid = (cycles % 2 == 0);
            default: tvalid = 1'($urandom % 2);
         endcase
         tdata = tx_q[sent];
         @(negedge clk);
         cycles++;
         if (hs_last) sent++;
      end
      tvalid = 1'b0;
      if (sent < tx_q.size()) check("stream_timeout", 32'(sent), 32'(tx_q.size()));
   endtask

   task automatic load_ramp(input int n);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'(i));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [7:0] d;

      // ALWAYS, bytes 0..15 back-to-back.
      do_reset(3'd0, 8'd1, 8'd1, 8'd1);
      load_ramp(16);
      run_stream(0, 100, cyc);
      check("always_cycles", 32'(cyc), 32'd17);
      check("always_beats", 32'(beat_cnt), 32'd16);
      check("always_last", 32'(last_data), 32'h0F);
      check("always_err", 32'(err_cnt), 32'd0);
      check("always_ready_stays", 32'(tready), 32'd1);

      // OSC 2 low / 6 high with valid held: 24 beats in 32 cycles after PRE.
      do_reset(3'd1, 8'd2, 8'd6, 8'd1);
      load_ramp(24);
      run_stream(0, 100, cyc);
      check("osc_cycles", 32'(cyc), 32'd33);
      check("osc_beats", 32'(beat_cnt), 32'd24);
      check("osc_last", 32'(last_data), 32'd23);

      // EVENTS=3, low_time=1, toggling valid.
      do_reset(3'd3, 8'd1, 8'd1, 8'd3);
      load_ramp(9);
      run_stream(1, 200, cyc);
      check("events_beats", 32'(beat_cnt), 32'd9);

      // AV_SINGLE low_time=4: ready rises 5 cycles after valid is first seen.
      do_reset(3'd5, 8'd4, 8'd1, 8'd1);
      repeat (9) @(negedge clk);
      check("av_idle_ready", 32'(tready), 32'd0);
      load_ramp(1);
      run_stream(0, 50, cyc);
      check("av_single_cycles", 32'(cyc), 32'd6);
      repeat (5) @(negedge clk);
      check("av_back_to_idle", 32'(tready), 32'd0);
      check("av_beats", 32'(beat_cnt), 32'd1);

      // Pattern checker: 0,1,5,6,7 has a single discontinuity.
      do_reset(3'd0, 8'd1, 8'd1, 8'd1);
      tx_q.delete();
      tx_q.push_back(8'd0); tx_q.push_back(8'd1); tx_q.push_back(8'd5);
      tx_q.push_back(8'd6); tx_q.push_back(8'd7);
      run_stream(0, 50, cyc);
      check("chk_err", 32'(err_cnt), 32'(EXP_ERR));
      check("chk_beats", 32'(beat_cnt), 32'd5);
      check("chk_last", 32'(last_data), 32'd7);

      // Reset mid-HIGH of OSC after 5 beats; the beat on the reset edge is dropped.
      do_reset(3'd1, 8'd2, 8'd8, 8'd1);
      load_ramp(5);
      run_stream(0, 50, cyc);
      check("rst_pre_cycles", 32'(cyc), 32'd8);
      check("rst_pre_ready", 32'(tready), 32'd1);
      tvalid = 1'b1; tdata = 8'h55; areset = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(tready), 32'd0);
      check("rst_beats", 32'(beat_cnt), 32'd0);
      check("rst_last", 32'(last_data), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      tvalid = 1'b0; areset = 1'b0;

      // Randomised segments with occasional live policy changes.
      for (int seg = 0; seg < 12; seg++) begin
         do_reset(3'($urandom % 8), 8'($urandom % 5), 8'($urandom % 5), 8'($urandom % 4));
         d = 8'($urandom);
         for (int c = 0; c < 80; c++) begin
            if ($urandom % 16 == 0) policy = 3'($urandom % 8);
            tvalid = 1'($urandom % 2);
            tdata  = d;
            @(negedge clk);
            if (hs_last) d = d + 8'd1;
            if ($urandom % 8 == 0) d = 8'($urandom);
         end
         tvalid = 1'b0;
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
